// File: rtl/criq_pkg.sv
// Shared helpers for the CSR/commit instruction queue: pointer sizing and
// elaboration-time legality checks of the queue geometry.
package criq_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Legal geometry: DEPTH a power of two and at least 4, 1 <= PEEK <= DEPTH.
    function automatic bit params_ok(input int depth, input int peek);
        return is_pow2(depth) && (depth >= 4) && (peek >= 1) && (peek <= depth);
    endfunction

endpackage

// File: rtl/criq_mem.sv
// Queue storage: two synchronous write ports (tail, tail+1) and PEEK
// asynchronous read ports returning entries base+k, wrapping modulo DEPTH.
// Contents are deliberately not reset.
module criq_mem
    import criq_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8,
    parameter int PEEK  = 6,
    parameter int PTRW  = 3
) (
    input  logic                  clk,
    input  logic                  we0,
    input  logic [PTRW-1:0]       addr0,
    input  logic [WIDTH-1:0]      data0,
    input  logic                  we1,
    input  logic [PTRW-1:0]       addr1,
    input  logic [WIDTH-1:0]      data1,
    input  logic [PTRW-1:0]       base,
    output logic [PEEK*WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write both ports; the two addresses always differ since DEPTH >= 4.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[addr0] <= data0;
        end
        if (we1) begin
            mem[addr1] <= data1;
        end
    end

    for (genvar k = 0; k < PEEK; k++) begin : g_rd
        logic [PTRW-1:0] addr;
        assign addr = base + PTRW'(k);
        assign rdata[k*WIDTH +: WIDTH] = mem[addr];
    end

endmodule

// File: rtl/criq_peek_queue.sv
// Circular instruction queue between decode and CSR execute/commit: up to two
// in-order pushes and one pop per cycle, exact occupancy tracking, and a head
// lookahead window of PEEK entries. Flushed by CriqClean on redirect.
//
// Handshake: there is no ready signal. A push of n entries (n = Wable0 +
// Wable1) is accepted all-or-nothing when DEPTH - count >= n at the start of
// the cycle; a pop is accepted when count > 0 at the start of the cycle. A
// same-cycle pop never creates room and a same-cycle push never feeds a pop.
// Rejections are reported through the sticky OvfErr / UdfErr flags.
module criq_peek_queue
    import criq_pkg::*;
#(
    parameter int  WIDTH = 23,
    parameter int  DEPTH = 8,
    parameter int  PEEK  = 6,
    localparam int PTRW  = clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic                  Wable0,
    input  logic [WIDTH-1:0]      Din0,
    input  logic                  Wable1,
    input  logic [WIDTH-1:0]      Din1,
    input  logic                  Rable,
    input  logic                  CriqClean,
    output logic [WIDTH-1:0]      Dout,
    output logic                  DoutValid,
    output logic [WIDTH-1:0]      CriqPreOut,
    output logic [PEEK*WIDTH-1:0] PeekData,
    output logic [PEEK-1:0]       PeekValid,
    output logic [PTRW:0]         CriqCount,
    output logic                  CriqFull,
    output logic                  CriqEmpty,
    output logic                  CriqRoom2,
    output logic                  OvfErr,
    output logic                  UdfErr
);

    localparam int CNTW = PTRW + 1;

    if (!params_ok(DEPTH, PEEK)) begin : g_bad_params
        $error("criq_peek_queue: DEPTH must be a power of two >= 4 and 1 <= PEEK <= DEPTH");
    end

    logic [PTRW-1:0]  head;
    logic [PTRW-1:0]  tail;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  free_slots;
    logic [CNTW-1:0]  push_n;
    logic [CNTW-1:0]  push_acc;
    logic             push_ok;
    logic             push_rej;
    logic             pop_ok;
    logic             mem_we0;
    logic             mem_we1;
    logic [WIDTH-1:0] mem_data0;
    logic [PTRW-1:0]  tail_plus1;

    // Acceptance decisions, judged only against start-of-cycle occupancy.
    always_comb begin
        free_slots = CNTW'(DEPTH) - count;
        push_n     = CNTW'(Wable0) + CNTW'(Wable1);
        push_ok    = (push_n != '0) && (free_slots >= push_n);
        push_rej   = (push_n != '0) && !push_ok;
        push_acc   = push_ok ? push_n : '0;
        pop_ok     = Rable && (count != '0);
        // A lone Wable1 entry still lands at tail; Din0 wins tail when both push.
        mem_data0  = Wable0 ? Din0 : Din1;
        mem_we0    = push_ok && !CriqClean;
        mem_we1    = push_ok && Wable0 && Wable1 && !CriqClean;
        tail_plus1 = tail + PTRW'(1);
    end

    criq_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PEEK  (PEEK),
        .PTRW  (PTRW)
    ) u_mem (
        .clk   (Clk),
        .we0   (mem_we0),
        .addr0 (tail),
        .data0 (mem_data0),
        .we1   (mem_we1),
        .addr1 (tail_plus1),
        .data1 (Din1),
        .base  (head),
        .rdata (PeekData)
    );

    // Pointer, occupancy, pop output and sticky error state; flush dominates.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            Dout      <= '0;
            DoutValid <= 1'b0;
            OvfErr    <= 1'b0;
            UdfErr    <= 1'b0;
        end else if (CriqClean) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            DoutValid <= 1'b0;
            OvfErr    <= 1'b0;
            UdfErr    <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTRW'(push_n);
            end
            if (pop_ok) begin
                head <= head + PTRW'(1);
                Dout <= CriqPreOut;
            end
            DoutValid <= pop_ok;
            count     <= count + push_acc - CNTW'(pop_ok);
            if (push_rej) begin
                OvfErr <= 1'b1;
            end
            if (Rable && !pop_ok) begin
                UdfErr <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < PEEK; k++) begin : g_pv
        assign PeekValid[k] = (CNTW'(k) < count);
    end

    assign CriqPreOut = PeekData[WIDTH-1:0];
    assign CriqCount  = count;
    assign CriqFull   = (count == CNTW'(DEPTH));
    assign CriqEmpty  = (count == '0);
    assign CriqRoom2  = (free_slots >= CNTW'(2));

endmodule

// File: tb/tb_criq_peek_queue.sv
// Directed bench for criq_peek_queue with WIDTH=8, DEPTH=8, PEEK=4.
module tb_criq_peek_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PEEK  = 4;
    localparam int CNTW  = 4;

    logic                  Clk;
    logic                  Rest;
    logic                  Wable0;
    logic [WIDTH-1:0]      Din0;
    logic                  Wable1;
    logic [WIDTH-1:0]      Din1;
    logic                  Rable;
    logic                  CriqClean;
    logic [WIDTH-1:0]      Dout;
    logic                  DoutValid;
    logic [WIDTH-1:0]      CriqPreOut;
    logic [PEEK*WIDTH-1:0] PeekData;
    logic [PEEK-1:0]       PeekValid;
    logic [CNTW-1:0]       CriqCount;
    logic                  CriqFull;
    logic                  CriqEmpty;
    logic                  CriqRoom2;
    logic                  OvfErr;
    logic                  UdfErr;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    criq_peek_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PEEK  (PEEK)
    ) dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .Wable0     (Wable0),
        .Din0       (Din0),
        .Wable1     (Wable1),
        .Din1       (Din1),
        .Rable      (Rable),
        .CriqClean  (CriqClean),
        .Dout       (Dout),
        .DoutValid  (DoutValid),
        .CriqPreOut (CriqPreOut),
        .PeekData   (PeekData),
        .PeekValid  (PeekValid),
        .CriqCount  (CriqCount),
        .CriqFull   (CriqFull),
        .CriqEmpty  (CriqEmpty),
        .CriqRoom2  (CriqRoom2),
        .OvfErr     (OvfErr),
        .UdfErr     (UdfErr)
    );

    // Clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] peek(input int k);
        return PeekData[k*WIDTH +: WIDTH];
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic w0, input logic [WIDTH-1:0] d0,
                         input logic w1, input logic [WIDTH-1:0] d1,
                         input logic r, input logic clean);
        Wable0    = w0;
        Din0      = d0;
        Wable1    = w1;
        Din1      = d1;
        Rable     = r;
        CriqClean = clean;
        @(posedge Clk);
        #1;
        Wable0    = 1'b0;
        Din0      = '0;
        Wable1    = 1'b0;
        Din1      = '0;
        Rable     = 1'b0;
        CriqClean = 1'b0;
    endtask

    task automatic push2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        drive(1'b1, a, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic push1(input logic [WIDTH-1:0] a);
        drive(1'b1, a, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Pop one entry and compare against the scoreboard head.
    task automatic pop_check(input string tag);
        logic [WIDTH-1:0] e;
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_dout"}, 32'(Dout), 32'(e));
            check_val({tag, "_dvalid"}, 32'(DoutValid), 32'(1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_count"}, 32'(CriqCount), 32'(0));
        check_val({tag, "_empty"}, 32'(CriqEmpty), 32'(1));
        check_val({tag, "_full"}, 32'(CriqFull), 32'(0));
        check_val({tag, "_room2"}, 32'(CriqRoom2), 32'(1));
        check_val({tag, "_pvalid"}, 32'(PeekValid), 32'(0));
        check_val({tag, "_dout"}, 32'(Dout), 32'(0));
        check_val({tag, "_dvalid"}, 32'(DoutValid), 32'(0));
        check_val({tag, "_ovf"}, 32'(OvfErr), 32'(0));
        check_val({tag, "_udf"}, 32'(UdfErr), 32'(0));
    endtask

    initial begin
        Rest = 1'b1;
        Wable0 = 1'b0; Din0 = '0; Wable1 = 1'b0; Din1 = '0;
        Rable = 1'b0; CriqClean = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("rst0");
        #2 Rest = 1'b0;

        // Single pushes on each port, pops, underflow, then async reset mid-cycle.
        drive(1'b0, '0, 1'b1, 8'h77, 1'b0, 1'b0);
        check_val("w1only_count", 32'(CriqCount), 32'(1));
        check_val("w1only_preout", 32'(CriqPreOut), 32'h77);
        push1(8'h66);
        check_val("w0only_slot1", 32'(peek(1)), 32'h66);
        check_val("w0only_pvalid", 32'(PeekValid), 32'b0011);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h66);
        pop_check("pre_pop0");
        pop_check("pre_pop1");
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check_val("pre_udf", 32'(UdfErr), 32'(1));
        check_val("pre_udf_dout", 32'(Dout), 32'h66);
        push1(8'h99);
        check_val("pre_count", 32'(CriqCount), 32'(1));
        #3 Rest = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        #2 Rest = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_val("post_rst_count", 32'(CriqCount), 32'(0));
        check_val("post_rst_dvalid", 32'(DoutValid), 32'(0));

        // Double push and peek window.
        push2(8'h11, 8'h22);
        check_val("dp_count2", 32'(CriqCount), 32'(2));
        check_val("dp_pvalid2", 32'(PeekValid), 32'b0011);
        push2(8'h33, 8'h44);
        check_val("dp_count4", 32'(CriqCount), 32'(4));
        check_val("dp_pvalid4", 32'(PeekValid), 32'b1111);
        check_val("dp_slot0", 32'(peek(0)), 32'h11);
        check_val("dp_slot1", 32'(peek(1)), 32'h22);
        check_val("dp_slot2", 32'(peek(2)), 32'h33);
        check_val("dp_slot3", 32'(peek(3)), 32'h44);
        check_val("dp_preout", 32'(CriqPreOut), 32'h11);

        // Pop ordering.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        pop_check("pop0");
        check_val("pop0_shift", 32'(CriqPreOut), 32'h22);
        pop_check("pop1");
        pop_check("pop2");
        pop_check("pop3");
        check_val("pop_empty", 32'(CriqEmpty), 32'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_val("idle_dvalid", 32'(DoutValid), 32'(0));
        check_val("idle_dout_hold", 32'(Dout), 32'h44);

        // Full and overflow.
        push2(8'h01, 8'h02);
        push2(8'h03, 8'h04);
        push2(8'h05, 8'h06);
        check_val("fill6_room2", 32'(CriqRoom2), 32'(1));
        push1(8'h07);
        check_val("fill7_count", 32'(CriqCount), 32'(7));
        check_val("fill7_room2", 32'(CriqRoom2), 32'(0));
        check_val("fill7_full", 32'(CriqFull), 32'(0));
        check_val("fill7_ovf", 32'(OvfErr), 32'(0));
        push2(8'hE8, 8'hE9);
        check_val("ovf_count", 32'(CriqCount), 32'(7));
        check_val("ovf_flag", 32'(OvfErr), 32'(1));
        push1(8'h08);
        check_val("full_count", 32'(CriqCount), 32'(8));
        check_val("full_full", 32'(CriqFull), 32'(1));
        check_val("full_room2", 32'(CriqRoom2), 32'(0));
        check_val("full_pvalid", 32'(PeekValid), 32'b1111);
        drive(1'b1, 8'hF9, 1'b0, '0, 1'b1, 1'b0);
        check_val("fullpp_count", 32'(CriqCount), 32'(7));
        check_val("fullpp_dout", 32'(Dout), 32'h01);
        for (int i = 2; i <= 8; i++) begin
            exp_q.push_back(WIDTH'(i));
        end
        for (int i = 0; i < 7; i++) begin
            pop_check("drain");
        end
        check_val("drain_empty", 32'(CriqEmpty), 32'(1));

        // Underflow with simultaneous push.
        drive(1'b1, 8'h5A, 1'b0, '0, 1'b1, 1'b0);
        check_val("udf_flag", 32'(UdfErr), 32'(1));
        check_val("udf_dvalid", 32'(DoutValid), 32'(0));
        check_val("udf_count", 32'(CriqCount), 32'(1));
        check_val("udf_dout_hold", 32'(Dout), 32'h08);
        exp_q.push_back(8'h5A);
        pop_check("udf_next");

        // Wrap of the peek window, then flush with push and pop.
        push1(8'hEE);
        exp_q.push_back(8'hEE);
        pop_check("wrap_align");
        push2(8'hA0, 8'hA1);
        push2(8'hA2, 8'hA3);
        check_val("wrap_count", 32'(CriqCount), 32'(4));
        check_val("wrap_slot0", 32'(peek(0)), 32'hA0);
        check_val("wrap_slot1", 32'(peek(1)), 32'hA1);
        check_val("wrap_slot2", 32'(peek(2)), 32'hA2);
        check_val("wrap_slot3", 32'(peek(3)), 32'hA3);
        drive(1'b1, 8'hBB, 1'b1, 8'hBC, 1'b1, 1'b1);
        check_val("flush_count", 32'(CriqCount), 32'(0));
        check_val("flush_empty", 32'(CriqEmpty), 32'(1));
        check_val("flush_ovf", 32'(OvfErr), 32'(0));
        check_val("flush_udf", 32'(UdfErr), 32'(0));
        check_val("flush_dvalid", 32'(DoutValid), 32'(0));
        check_val("flush_dout", 32'(Dout), 32'hEE);

        // Double push from tail = DEPTH-1 writes slots 7 and 0.
        push2(8'hC1, 8'hC2);
        push2(8'hC3, 8'hC4);
        push2(8'hC5, 8'hC6);
        push1(8'hC7);
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back(8'hC0 + WIDTH'(i));
        end
        for (int i = 0; i < 7; i++) begin
            pop_check("tailwrap_drain");
        end
        push2(8'hD0, 8'hD1);
        check_val("tailwrap_count", 32'(CriqCount), 32'(2));
        check_val("tailwrap_slot0", 32'(peek(0)), 32'hD0);
        check_val("tailwrap_slot1", 32'(peek(1)), 32'hD1);
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hD1);
        pop_check("tailwrap_pop0");
        pop_check("tailwrap_pop1");
        check_val("tailwrap_empty", 32'(CriqEmpty), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
